// File: rtl/mult32x32_job_ctrl_if.sv
// Handshake and multiplier-side bundle for the 32x32 multiplier job front-end.
// The master modport is the job controller; slave is the mirror seen by the
// operand source, multiplier and result consumer.
interface mult32x32_job_ctrl_if #(
  parameter int DEPTH = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_a;
  logic [31:0]               in_b;
  logic                      mult_start;
  logic [31:0]               mult_a;
  logic [31:0]               mult_b;
  logic                      mult_busy;
  logic [63:0]               mult_product;
  logic                      out_valid;
  logic                      out_ready;
  logic [63:0]               out_product;
  logic [$clog2(DEPTH)+1:0]  jobs_pending;
  logic                      err;

  modport master (
    input  in_valid, in_a, in_b, mult_busy, mult_product, out_ready,
    output in_ready, mult_start, mult_a, mult_b, out_valid, out_product,
           jobs_pending, err
  );

  modport slave (
    output in_valid, in_a, in_b, mult_busy, mult_product, out_ready,
    input  in_ready, mult_start, mult_a, mult_b, out_valid, out_product,
           jobs_pending, err
  );
endinterface

// File: rtl/mult32x32_job_ctrl.sv
// Job front-end for the 32x32 fast multiplier.
// Operand pairs are queued in a small FIFO, launched one at a time with a
// single-cycle start pulse, held stable while the multiplier runs, and the
// 64-bit product is returned through a one-entry valid/ready output register.
module mult32x32_job_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mult32x32_job_ctrl_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  // operand FIFO
  logic [31:0]    mem_a_r [DEPTH];
  logic [31:0]    mem_b_r [DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;

  // control and datapath
  logic [2:0]     state_r;
  logic [2:0]     state_next_s;
  logic           push_s;
  logic           pop_s;
  logic           capture_s;
  logic           drain_s;
  logic           slot_free_s;
  logic           err_set_s;
  logic           inflight_s;
  logic [31:0]    mult_a_r;
  logic [31:0]    mult_b_r;
  logic           start_r;
  logic           out_valid_r;
  logic [63:0]    out_product_r;
  logic           err_r;

  // Next-state decode: FIFO handshakes, job sequencing and result capture
  always_comb begin
    push_s       = bus.in_valid && (count_r != DEPTH_C);
    slot_free_s  = !out_valid_r || bus.out_ready;
    drain_s      = out_valid_r && bus.out_ready;
    inflight_s   = (state_r != ST_IDLE);
    pop_s        = 1'b0;
    capture_s    = 1'b0;
    err_set_s    = 1'b0;
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        // a push in this cycle is not visible until the count register updates
        if (count_r != {CW{1'b0}}) begin
          pop_s        = 1'b1;
          state_next_s = ST_LAUNCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_next_s = ST_CHECK;
      end
      ST_CHECK: begin
        // the multiplier must acknowledge the start one cycle later
        if (!bus.mult_busy) begin
          err_set_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.mult_busy) begin
          state_next_s = ST_RUN;
        end else if (slot_free_s) begin
          capture_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // product register stays frozen while we wait for the output slot
        if (slot_free_s) begin
          capture_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage write (data needs no reset; validity is tracked by count_r)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_a_r[wr_ptr_r] <= bus.in_a;
      mem_b_r[wr_ptr_r] <= bus.in_b;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM, operand hold registers, start pulse, result register and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      start_r       <= 1'b0;
      mult_a_r      <= 32'h0000_0000;
      mult_b_r      <= 32'h0000_0000;
      out_valid_r   <= 1'b0;
      out_product_r <= 64'h0;
      err_r         <= 1'b0;
    end else begin
      state_r <= state_next_s;
      // the pop cycle moves to LAUNCH, so the start pulse lines up with it
      start_r <= pop_s;
      if (pop_s) begin
        mult_a_r <= mem_a_r[rd_ptr_r];
        mult_b_r <= mem_b_r[rd_ptr_r];
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end
      // capture wins over a simultaneous drain: the old result still hands off
      if (capture_s) begin
        out_product_r <= bus.mult_product;
        out_valid_r   <= 1'b1;
      end else if (drain_s) begin
        out_valid_r   <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = (count_r != DEPTH_C);
  assign bus.mult_start   = start_r;
  assign bus.mult_a       = mult_a_r;
  assign bus.mult_b       = mult_b_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_product  = out_product_r;
  assign bus.err          = err_r;
  assign bus.jobs_pending = {1'b0, count_r}
                          + {{CW{1'b0}}, inflight_s}
                          + {{CW{1'b0}}, out_valid_r};
endmodule
